// File: rtl/single_unit_network_interface_pkg.sv
// Shared types and header field layout for the single-unit network interface.
package single_unit_network_interface_pkg;

    typedef enum logic [1:0] {
        FT_HEAD     = 2'd0,
        FT_BODY     = 2'd1,
        FT_TAIL     = 2'd2,
        FT_HEADTAIL = 2'd3
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_e;

    // Destination id sits in the lowest bits of a head flit.
    function automatic int unsigned dst_lsb();
        return 0;
    endfunction

    // Source id follows the destination id.
    function automatic int unsigned src_lsb(input int unsigned node_id_size);
        return node_id_size;
    endfunction

    // Payload occupies everything above the two ids.
    function automatic int unsigned payload_lsb(input int unsigned node_id_size);
        return 2 * node_id_size;
    endfunction

endpackage

// File: rtl/single_unit_network_interface_fifo.sv
// Show-ahead FIFO: data_o always reflects the oldest entry while not empty.
module single_unit_network_interface_fifo #(
    parameter int unsigned WIDTH = 66,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO rejects a push even when a pop happens in the same cycle.
    assign full_o  = (count_o == CNT_W'(DEPTH));
    assign empty_o = (count_o == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];

    // Storage write; contents need no reset because reads are gated by count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers wrap modulo DEPTH; occupancy tracks push/pop balance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: rtl/single_unit_network_interface_ejector.sv
// Receive path: buffers router flits, checks headers, streams payload beats to the unit.
module single_unit_network_interface_ejector
    import single_unit_network_interface_pkg::*;
#(
    parameter int unsigned FLIT_SIZE      = 64,
    parameter int unsigned FLIT_TYPE_SIZE = 2,
    parameter int unsigned NODE_ID_SIZE   = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned LOCAL_ID       = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [FLIT_SIZE-1:0]      flit_i,
    input  logic [FLIT_TYPE_SIZE-1:0] flit_type_i,
    input  logic                      flit_valid_i,
    output logic                      credit_o,
    output logic [FLIT_SIZE-1:0]      m_tdata_o,
    output logic [NODE_ID_SIZE-1:0]   m_tid_o,
    output logic                      m_tlast_o,
    output logic                      m_tvalid_o,
    input  logic                      m_tready_i,
    output logic                      err_dest_o,
    output logic                      err_proto_o,
    output logic                      err_ovf_o
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENTRY_W = FLIT_SIZE + FLIT_TYPE_SIZE;
    localparam int unsigned DST_LSB = dst_lsb();
    localparam int unsigned SRC_LSB = src_lsb(NODE_ID_SIZE);
    localparam int unsigned PAY_LSB = payload_lsb(NODE_ID_SIZE);

    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic [ENTRY_W-1:0]        fifo_rdata;

    logic [FLIT_SIZE-1:0]      head_flit;
    flit_type_e                head_type;
    logic [NODE_ID_SIZE-1:0]   head_dst;
    logic [NODE_ID_SIZE-1:0]   head_src;
    logic [FLIT_SIZE-1:0]      head_payload;
    logic                      head_local;
    logic                      ovf_c;

    state_e                    state_q;
    state_e                    state_d;
    logic [NODE_ID_SIZE-1:0]   tid_q;
    logic [NODE_ID_SIZE-1:0]   tid_d;
    logic                      use_src_c;
    logic                      set_dest_c;
    logic                      set_proto_c;

    // Flit and its type travel together through the ingress buffer.
    single_unit_network_interface_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  ({flit_type_i, flit_i}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Ingress admission and header field decode of the buffer head.
    assign fifo_push    = flit_valid_i && !fifo_full;
    assign ovf_c        = flit_valid_i && (fifo_count == CNT_W'(FIFO_DEPTH));
    assign head_flit    = fifo_rdata[FLIT_SIZE-1:0];
    assign head_type    = flit_type_e'(2'(fifo_rdata[ENTRY_W-1:FLIT_SIZE]));
    assign head_dst     = NODE_ID_SIZE'(head_flit >> DST_LSB);
    assign head_src     = NODE_ID_SIZE'(head_flit >> SRC_LSB);
    assign head_payload = FLIT_SIZE'(head_flit >> PAY_LSB);
    assign head_local   = (head_dst == NODE_ID_SIZE'(LOCAL_ID));

    // Id follows the buffer head for a single-flit message, else the latched source.
    assign m_tid_o = use_src_c ? head_src : tid_q;

    // Next-state, pop and beat presentation.
    always_comb begin
        state_d     = state_q;
        tid_d       = tid_q;
        fifo_pop    = 1'b0;
        m_tvalid_o  = 1'b0;
        m_tlast_o   = 1'b0;
        m_tdata_o   = '0;
        use_src_c   = 1'b0;
        set_dest_c  = 1'b0;
        set_proto_c = 1'b0;
        if (!fifo_empty) begin
            case (state_q)
                ST_IDLE: begin
                    case (head_type)
                        FT_HEAD: begin
                            fifo_pop = 1'b1;
                            if (head_local) begin
                                tid_d   = head_src;
                                state_d = ST_PAYLOAD;
                            end else begin
                                set_dest_c = 1'b1;
                                state_d    = ST_DROP;
                            end
                        end
                        FT_HEADTAIL: begin
                            if (head_local) begin
                                m_tvalid_o = 1'b1;
                                m_tlast_o  = 1'b1;
                                m_tdata_o  = head_payload;
                                use_src_c  = 1'b1;
                                fifo_pop   = m_tready_i;
                            end else begin
                                fifo_pop   = 1'b1;
                                set_dest_c = 1'b1;
                            end
                        end
                        default: begin
                            fifo_pop    = 1'b1;
                            set_proto_c = 1'b1;
                        end
                    endcase
                end
                ST_PAYLOAD: begin
                    case (head_type)
                        FT_BODY, FT_TAIL: begin
                            m_tvalid_o = 1'b1;
                            m_tlast_o  = (head_type == FT_TAIL);
                            m_tdata_o  = head_flit;
                            fifo_pop   = m_tready_i;
                            if (m_tready_i && (head_type == FT_TAIL)) begin
                                state_d = ST_IDLE;
                            end
                        end
                        default: begin
                            fifo_pop    = 1'b1;
                            set_proto_c = 1'b1;
                        end
                    endcase
                end
                ST_DROP: begin
                    fifo_pop = 1'b1;
                    if (head_type == FT_TAIL) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, message id, credit pulse and sticky error flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            tid_q       <= '0;
            credit_o    <= 1'b0;
            err_dest_o  <= 1'b0;
            err_proto_o <= 1'b0;
            err_ovf_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tid_q       <= tid_d;
            credit_o    <= fifo_pop;
            err_dest_o  <= err_dest_o | set_dest_c;
            err_proto_o <= err_proto_o | set_proto_c;
            err_ovf_o   <= err_ovf_o | ovf_c;
        end
    end

endmodule

// File: doc/single_unit_network_interface_ejector.md
# single_unit_network_interface_ejector

- Receive path of the single-unit network interface: accepts flits ejected by the local NoC router and returns credits for them.
- Strips and checks the head flit, then delivers message payload to the attached unit as a valid/ready beat stream with source id and last marker.
- Complements the injection path, which packetizes unit messages into flits.

## Interface
Parameters:
- FLIT_SIZE, 64, flit width in bits, including header fields.
- FLIT_TYPE_SIZE, 2, width of the flit type sideband.
- NODE_ID_SIZE, 8, width of source and destination node ids.
- FIFO_DEPTH, 4, ingress buffer depth in flits; the router's initial credit count.
- LOCAL_ID, 0, node id of this interface.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Asynchronous, active-low.
- flit_i  in  FLIT_SIZE  flit from the router.
- flit_type_i  in  FLIT_TYPE_SIZE  flit type: 0=head, 1=body, 2=tail, 3=headtail.
- flit_valid_i  in  1  flit present this cycle; no ready signal, flow control is credit-based.
- credit_o  out  1  one-cycle pulse per flit removed from the buffer.
- m_tdata_o  out  FLIT_SIZE  payload beat.
- m_tid_o  out  NODE_ID_SIZE  source node of the current message.
- m_tlast_o  out  1  last beat of the message.
- m_tvalid_o  out  1  beat valid.
- m_tready_i  in  1  unit accepts the beat.
- err_dest_o  out  1  sticky: a head's destination was not LOCAL_ID.
- err_proto_o  out  1  sticky: a flit arrived out of sequence.
- err_ovf_o  out  1  sticky: a flit arrived while the buffer was full.

## Operation
Header fields (head and headtail flits):
- dst = flit[NODE_ID_SIZE-1:0].
- src = flit[2*NODE_ID_SIZE-1:NODE_ID_SIZE].
- Payload field = remaining upper bits.

Ingress buffer:
- Every valid flit is pushed into a show-ahead FIFO together with its type, unless the FIFO is full.
- If full, the flit is discarded and err_ovf_o is set; no credit is returned for it.
- A push is rejected when full even if a pop occurs in the same cycle.

FSM states: IDLE, PAYLOAD, DROP. Reset state is IDLE.

IDLE, FIFO non-empty:
- head, dst==LOCAL_ID: pop without a handshake; latch src into m_tid_o; go to PAYLOAD.
- head, dst!=LOCAL_ID: pop; set err_dest_o; go to DROP.
- headtail, dst==LOCAL_ID: present one beat with m_tdata_o = payload field zero-extended, m_tid_o = src, m_tlast_o=1. Pop on handshake; stay in IDLE.
- headtail, dst!=LOCAL_ID: pop; set err_dest_o; stay in IDLE.
- body or tail: pop; set err_proto_o; stay in IDLE.

PAYLOAD:
- body: present it as m_tdata_o=flit, m_tlast_o=0. Pop on handshake.
- tail: present it with m_tlast_o=1. Pop on handshake, then go to IDLE.
- head or headtail: pop without presenting; set err_proto_o; stay in PAYLOAD.

DROP:
- Pop every flit without a handshake.
- On popping a tail, go to IDLE.

General rules:
- m_tvalid_o is asserted only in PAYLOAD with body/tail at the FIFO head, or in IDLE with a local headtail at the head.
- When m_tvalid_o=1, data, last and id stay stable until the handshake.
- Error flags are cleared only by reset.

## Timing
- Reset values: credit_o=0, m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, m_tid_o=0, all error flags 0, FIFO empty, state IDLE.
- Reset asserted mid-message discards the buffer and the message state; no credits are returned for flushed flits.
- A flit pushed at edge N can drive m_tvalid_o=1 in cycle N+1 (one-cycle latency).
- A head pushed at edge N is popped at edge N+1; a body pushed at edge N+1 is valid in cycle N+2.
- credit_o is registered: it is high for exactly the one cycle after each pop edge.
- Sustained throughput is one flit per cycle when m_tready_i=1.
- Simultaneous push and pop on a non-full FIFO: both occur and the occupancy is unchanged.
- The FIFO pointers wrap modulo FIFO_DEPTH.
- Occupancy is tracked with a counter of width $clog2(FIFO_DEPTH+1).

## Structure
- Shared package single_unit_network_interface_pkg holds:
  - the flit-type enum (HEAD, BODY, TAIL, HEADTAIL);
  - the header field offset functions;
  - the FSM state enum.
- Sub-module single_unit_network_interface_fifo: a parameterized show-ahead FIFO providing full/empty/count.
- The FSM, credit register and error flags live in the top module.

## Test plan
- LOCAL_ID=3. Head(dst=3, src=7), body 0xA, tail 0xB, with tready=1 → two beats 0xA (last=0), 0xB (last=1); tid=7; three credit pulses; no errors.
- Head(dst=5) followed by two bodies and a tail → no beats; err_dest_o=1; four credits; the next valid message is delivered normally.
- Local headtail with payload 0x1234 → one beat 0x1234 with last=1, tid=src.
- Head, then 4 bodies with tready=0 → FIFO fills. A fifth flit sets err_ovf_o and returns no credit. Releasing tready drains 4 beats and returns 5 credits in total: head + 4 bodies.
- Body arriving in IDLE → dropped; err_proto_o=1; one credit.
- Reset asserted after a head and one body → outputs return to reset values; a subsequent full message delivers correctly.
